// File: rtl/axis_arb_pkg.sv
// Shared types and derived widths for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

  // Output tdata is the input width padded up to a byte boundary.
  function automatic int tdata_w(input int data_w);
    return sizing::closest_8_multiple(data_w);
  endfunction

  function automatic int id_w(input int n);
    return sizing::encoding_size(n);
  endfunction

  // Counter must be able to hold MAX_BEATS itself, since it saturates there.
  function automatic int cnt_w(input int max_beats);
    return sizing::bit_size(max_beats);
  endfunction

endpackage

// File: rtl/sizing.sv
// Width helpers shared by stream blocks: byte-rounded data widths,
// index widths and counter widths.
package sizing;

  // Round a bit width up to the next whole byte.
  function automatic int closest_8_multiple(input int x);
    return ((x + 7) / 8) * 8;
  endfunction

  // Bits needed to index n items; never below 1 so single-item buses still exist.
  function automatic int encoding_size(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value v itself (not v-1).
  function automatic int bit_size(input int v);
    return (v <= 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = sizing::encoding_size(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  // Walk the requests starting from ptr; the first hit locks the result.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = ID_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: N AXI-Stream inputs share one output.
// A grant is held from arbitration until the tlast beat; one idle cycle
// separates packets while the next winner is chosen.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int DATA_W    = 12,
  parameter  int MAX_BEATS = 256,
  localparam int TDATA_W   = tdata_w(DATA_W),
  localparam int ID_W      = id_w(N),
  localparam int CNT_W     = cnt_w(MAX_BEATS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        s_tvalid,
  output logic [N-1:0]        s_tready,
  input  logic [N-1:0]        s_tlast,
  input  logic [N*DATA_W-1:0] s_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [TDATA_W-1:0]  m_tdata,
  output logic [ID_W-1:0]     m_tid,
  output logic                busy,
  output logic                err_overlong,
  input  logic                err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N - 1);

  arb_state_t               state;
  logic [ID_W-1:0]          ptr;
  logic [ID_W-1:0]          grant;
  logic [ID_W-1:0]          pick_idx;
  logic                     pick_any;
  logic [CNT_W-1:0]         beat_cnt;
  logic [N-1:0][DATA_W-1:0] data_arr;
  logic                     beat;
  logic                     set_err;

  assign data_arr = s_tdata;
  assign busy     = (state == ARB_BUSY);
  assign beat     = m_tvalid && m_tready;
  // Overlong: the beat that brings the count up to MAX_BEATS without tlast.
  assign set_err  = beat && !m_tlast && (beat_cnt == CNT_PRE);

  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .req (s_tvalid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Output mux: straight pass-through of the granted requester while busy, all zero when idle.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tid    = '0;
    s_tready = '0;
    if (busy) begin
      m_tvalid = s_tvalid[grant];
      m_tlast  = s_tlast[grant];
      m_tdata  = TDATA_W'(data_arr[grant]);
      m_tid    = grant;
    end
    for (int i = 0; i < N; i++)
      s_tready[i] = busy && (grant == ID_W'(i)) && m_tready;
  end

  // Arbitration FSM: pick in IDLE, hold the grant through the tlast beat, then advance ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant    <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (beat) begin
            if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + CNT_W'(1);
            if (m_tlast) begin
              state <= ARB_IDLE;
              ptr   <= (grant == LAST_ID) ? '0 : grant + ID_W'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Sticky overlong flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_overlong <= 1'b0;
    else if (set_err) err_overlong <= 1'b1;
    else if (err_clr) err_overlong <= 1'b0;
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter (N=4, DATA_W=12, MAX_BEATS=4): a directed
// cycle table, hand sequences for overlong/async reset, then random traffic
// against a packet-level reference model.
module tb_axis_rr_arbiter;

  localparam int N = 4;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  vld, lst, s_tready;
  logic        rdy, clr;
  logic [11:0] dat [4];
  logic [47:0] s_tdata;
  logic        m_tvalid, m_tlast, busy, err_overlong;
  logic [15:0] m_tdata;
  logic [1:0]  m_tid;

  int tests = 0;
  int fails = 0;

  assign s_tdata = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  axis_rr_arbiter #(.N(N), .DATA_W(12), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(vld), .s_tready(s_tready), .s_tlast(lst), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(rdy), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .m_tid(m_tid), .busy(busy), .err_overlong(err_overlong), .err_clr(clr)
  );

  typedef struct {
    logic [3:0] v, l;
    logic       r;
    logic       mv, ml;
    logic [1:0] tid;
    logic [3:0] sr;
    logic       b;
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(input logic [3:0] v, l, input logic r, mv, ml,
                              input logic [1:0] tid, input logic [3:0] sr, input logic b);
    vec_t x;
    x.v = v; x.l = l; x.r = r; x.mv = mv; x.ml = ml; x.tid = tid; x.sr = sr; x.b = b;
    return x;
  endfunction

  function automatic vec_t idle(input logic [3:0] v);
    return mk(v, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
  endfunction

  function automatic logic [31:0] snap();
    return {6'b0, m_tvalid, m_tlast, m_tid, s_tready, busy, err_overlong, m_tdata};
  endfunction

  function automatic logic [31:0] epack(input logic mv, ml, input logic [1:0] tid,
                                        input logic [3:0] sr, input logic b, e,
                                        input logic [15:0] d);
    return {6'b0, mv, ml, tid, sr, b, e, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; vld = '0; lst = '0; rdy = 1'b1; clr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // random-phase state
  int          owner, mptr, mcnt, rem [4], seq [4], w;
  logic        merr, mbeat, mset;
  logic [3:0]  hs, esr;
  logic [15:0] ed;

  initial begin
    dat[0] = 12'hABC; dat[1] = 12'h111; dat[2] = 12'h222; dat[3] = 12'h333;
    rst_n = 1'b0; vld = 4'hF; lst = '0; rdy = 1'b1; clr = 1'b0;

    // rotation 0,1,2,3,0 with 2-beat packets, then wrap from ptr=2, then ready toggling
    tbl[0]  = idle(4'hF);
    tbl[1]  = mk(4'hF, 4'h0, 1, 1, 0, 2'd0, 4'b0001, 1);
    tbl[2]  = mk(4'hF, 4'hF, 1, 1, 1, 2'd0, 4'b0001, 1);
    tbl[3]  = idle(4'hF);
    tbl[4]  = mk(4'hF, 4'h0, 1, 1, 0, 2'd1, 4'b0010, 1);
    tbl[5]  = mk(4'hF, 4'hF, 1, 1, 1, 2'd1, 4'b0010, 1);
    tbl[6]  = idle(4'hF);
    tbl[7]  = mk(4'hF, 4'h0, 1, 1, 0, 2'd2, 4'b0100, 1);
    tbl[8]  = mk(4'hF, 4'hF, 1, 1, 1, 2'd2, 4'b0100, 1);
    tbl[9]  = idle(4'hF);
    tbl[10] = mk(4'hF, 4'h0, 1, 1, 0, 2'd3, 4'b1000, 1);
    tbl[11] = mk(4'hF, 4'hF, 1, 1, 1, 2'd3, 4'b1000, 1);
    tbl[12] = idle(4'hF);
    tbl[13] = mk(4'hF, 4'h0, 1, 1, 0, 2'd0, 4'b0001, 1);
    tbl[14] = mk(4'hF, 4'hF, 1, 1, 1, 2'd0, 4'b0001, 1);
    tbl[15] = idle(4'hF);
    tbl[16] = mk(4'hF, 4'h0, 1, 1, 0, 2'd1, 4'b0010, 1);
    tbl[17] = mk(4'hF, 4'hF, 1, 1, 1, 2'd1, 4'b0010, 1);
    tbl[18] = idle(4'b0011);
    tbl[19] = mk(4'b0011, 4'h0, 1, 1, 0, 2'd0, 4'b0001, 1);
    tbl[20] = mk(4'b0011, 4'hF, 1, 1, 1, 2'd0, 4'b0001, 1);
    tbl[21] = idle(4'b1000);
    tbl[22] = mk(4'hF, 4'h0, 1, 1, 0, 2'd3, 4'b1000, 1);
    tbl[23] = mk(4'hF, 4'h0, 0, 1, 0, 2'd3, 4'b0000, 1);
    tbl[24] = mk(4'hF, 4'h0, 1, 1, 0, 2'd3, 4'b1000, 1);
    tbl[25] = mk(4'hF, 4'hF, 0, 1, 1, 2'd3, 4'b0000, 1);
    tbl[26] = mk(4'hF, 4'hF, 1, 1, 1, 2'd3, 4'b1000, 1);
    tbl[27] = idle(4'hF);
    tbl[28] = mk(4'hF, 4'h0, 1, 1, 0, 2'd0, 4'b0001, 1);

    // reset held with all requests pending: everything quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", snap(), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      vld = tbl[r].v; lst = tbl[r].l; rdy = tbl[r].r;
      @(negedge clk);
      chk($sformatf("table_row%0d", r), snap(),
          epack(tbl[r].mv, tbl[r].ml, tbl[r].tid, tbl[r].sr, tbl[r].b, 1'b0,
                tbl[r].b ? {4'h0, dat[tbl[r].tid]} : 16'h0));
      @(posedge clk); #1;
    end

    // overlong 6-beat packet: flag rises on beat 4 with clear in the same cycle, clears next
    do_reset();
    vld = 4'b0001; lst = '0; rdy = 1'b1;
    @(posedge clk); #1;
    for (int b = 1; b <= 6; b++) begin
      lst = (b == 6) ? 4'b0001 : 4'b0000;
      clr = (b == 4 || b == 5);
      @(negedge clk);
      chk($sformatf("ovl_busy_b%0d", b), {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("ovl_err_b%0d", b), {31'b0, err_overlong}, {31'b0, b == 4});
    end
    clr = 1'b0; vld = '0;
    chk("ovl_done_idle", {31'b0, busy}, 32'd0);

    // async reset during beat 2 of a packet from requester 2
    do_reset();
    vld = 4'b0100; lst = '0; rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_pkt_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", snap(), 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b1; vld = 4'hF;
    #1 chk("post_rst_idle", snap(), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_ptr0", snap(), epack(1, 0, 2'd0, 4'b0001, 1, 0, 16'h0ABC));

    // random traffic against a packet-level model
    do_reset();
    owner = -1; mptr = 0; mcnt = 0; merr = 1'b0; hs = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = $urandom_range(1, 6); seq[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          seq[i]++; rem[i]--;
          if (rem[i] == 0) rem[i] = $urandom_range(1, 6);
          vld[i] = ($urandom % 4) != 0;
        end else if (!vld[i]) vld[i] = ($urandom % 2) != 0;
        else vld[i] = ($urandom % 10) != 0;
        lst[i] = (rem[i] == 1);
        dat[i] = 12'((i << 10) | (seq[i] & 1023));
      end
      rdy = ($urandom % 4) != 0;
      clr = ($urandom % 16) == 0;
      @(negedge clk);
      esr = '0;
      ed  = '0;
      if (owner >= 0) begin
        esr[owner] = rdy;
        ed = {4'h0, dat[owner]};
      end
      chk("random", snap(),
          epack(owner >= 0 ? vld[owner] : 1'b0, owner >= 0 ? lst[owner] : 1'b0,
                owner >= 0 ? 2'(owner) : 2'd0, esr, owner >= 0, merr, ed));
      hs = vld & esr;
      mset = 1'b0;
      if (owner < 0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && vld[(mptr + k) % N]) w = (mptr + k) % N;
        if (w >= 0) begin owner = w; mcnt = 0; end
      end else begin
        mbeat = vld[owner] && rdy;
        mset  = mbeat && !lst[owner] && (mcnt + 1 == MAXB);
        if (mbeat && mcnt < MAXB) mcnt++;
        if (mbeat && lst[owner]) begin
          mptr  = (owner + 1) % N;
          owner = -1;
        end
      end
      if (mset) merr = 1'b1;
      else if (clr) merr = 1'b0;
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
